// File: rtl/branch_target_pkg.sv
// Shared constants, FSM states and record-field positions for the branch-target loader.
// Holds no logic, so it adds no latency and applies no backpressure.
package branch_target_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 1 << ADDR_W;

  // Layout of the first record byte: {last, rsvd[1:0], addr[4:0]}
  localparam int LAST_BIT = 7;
  localparam int RSVD_HI  = 6;
  localparam int RSVD_LO  = 5;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    HI,
    LO,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/branch_target_if.sv
// Byte-stream handshake plus the fetch-side pointer/target read port.
// Wiring only: the slave drives InReady and Target, and the master drives everything else.
interface branch_target_if;
  import branch_target_pkg::*;

  logic [7:0]        InData;
  logic              InValid;
  logic              InReady;
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] Target;

  modport master (output InData, InValid, Addr, input InReady, Target);
  modport slave  (input InData, InValid, Addr, output InReady, Target);

endinterface

// File: rtl/branch_target_loader_regfile.sv
// DEPTH x DATA_W target table: write takes effect at the clock edge, read is combinational.
// A read of the entry being written returns the old value until after that edge. No backpressure.
module target_regfile
  import branch_target_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/branch_target_loader.sv
// Loads 3-byte (addr, target) records into the target table; each write commits at the edge that accepts the low byte.
// InReady depends on state only: it is high in ADDR, HI and LO, and low in every other state.
module branch_target_loader
  import branch_target_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  branch_target_if.slave    bus,
  output logic              Busy,
  output logic              Done,
  output logic              Error,
  output logic [ADDR_W:0]   Count
);

  localparam int               TMO_W   = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT);
  localparam logic [ADDR_W:0]  CNT_MAX = (ADDR_W + 1)'(DEPTH);

  loader_state_t     state_q, state_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic              last_q, last_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              xfer;
  logic              we;
  logic [DATA_W-1:0] target;

  assign bus.InReady = (state_q == ADDR) || (state_q == HI) || (state_q == LO);
  assign xfer        = bus.InValid && bus.InReady;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      waddr_q <= '0;
      last_q  <= 1'b0;
      hi_q    <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      last_q  <= last_d;
      hi_q    <= hi_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    waddr_d = waddr_q;
    last_d  = last_q;
    hi_d    = hi_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    we      = 1'b0;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (Start) begin
          state_d = ADDR;
          cnt_d   = '0;
          tmo_d   = '0;
        end
      end
      ADDR: begin
        if (xfer) begin
          if (|bus.InData[RSVD_HI:RSVD_LO]) begin
            state_d = ERR;
          end else begin
            waddr_d = bus.InData[ADDR_W-1:0];
            last_d  = bus.InData[LAST_BIT];
            tmo_d   = '0;
            state_d = HI;
          end
        end
      end
      HI, LO: begin
        if (xfer) begin
          tmo_d = '0;
          if (state_q == HI) begin
            hi_d    = bus.InData;
            state_d = LO;
          end else begin
            we      = 1'b1;
            cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
            state_d = last_q ? DONE : ADDR;
          end
        end else begin
          // Only a stall inside a record counts toward the timeout.
          tmo_d = tmo_q + 1'b1;
          if (tmo_d == TMO_LIM) state_d = ERR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  target_regfile u_regfile (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .we_i    (we),
    .waddr_i (waddr_q),
    .wdata_i ({hi_q, bus.InData}),
    .raddr_i (bus.Addr),
    .rdata_o (target)
  );

  assign bus.Target = target;
  assign Busy       = bus.InReady;
  assign Done       = (state_q == DONE);
  assign Error      = (state_q == ERR);
  assign Count      = cnt_q;

endmodule

// File: tb/tb_branch_target_loader.sv
// Randomized bench for the branch-target loader, checked against a record-level table model.
module tb_branch_target_loader;
  import branch_target_pkg::*;

  localparam int TMO = 255;

  logic            Clk = 1'b0;
  logic            Reset;
  logic            Start;
  logic            Busy, Done, Error;
  logic [ADDR_W:0] Count;

  branch_target_if bus();

  branch_target_loader #(.TIMEOUT(TMO)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .bus   (bus),
    .Busy  (Busy),
    .Done  (Done),
    .Error (Error),
    .Count (Count)
  );

  always #5 Clk = ~Clk;

  int          n_chk = 0;
  int          n_err = 0;
  logic [15:0] ref_tab [DEPTH];
  int          ref_cnt;
  bit          ref_done, ref_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) ref_tab[i] = 16'h0000;
    ref_cnt  = 0;
    ref_done = 0;
    ref_err  = 0;
  endtask

  // Idle for gap cycles, then offer one byte and wait (bounded) for the transfer edge.
  task automatic push(input logic [7:0] b, input int gap);
    bus.InValid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      check("rdy_in_gap", bus.InReady, 1'b1);
      tick();
    end
    bus.InData  = b;
    bus.InValid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bus.InReady) begin
        tick();
        bus.InValid = 1'b0;
        return;
      end
      tick();
    end
    check("handshake_rdy", bus.InReady, 1'b1);
    bus.InValid = 1'b0;
  endtask

  task automatic send_rec(input logic [7:0] b0, input logic [15:0] tgt, input int gap,
                          output bit stop);
    logic [ADDR_W-1:0] a;
    a    = b0[ADDR_W-1:0];
    stop = 1'b0;
    push(b0, gap);
    if (b0[6:5] != 2'b00) begin
      ref_err = 1;
      stop    = 1'b1;
      return;
    end
    push(tgt[15:8], gap);
    bus.Addr = a;
    #1;
    check("prewrite", bus.Target, ref_tab[a]);
    push(tgt[7:0], gap);
    ref_tab[a] = tgt;
    if (ref_cnt < DEPTH) ref_cnt++;
    #1;
    check("postwrite", bus.Target, tgt);
    if (b0[7]) begin
      ref_done = 1;
      stop     = 1'b1;
    end
  endtask

  task automatic start_session();
    Start = 1'b1;
    tick();
    Start    = 1'b0;
    ref_done = 0;
    ref_err  = 0;
    ref_cnt  = 0;
    check("busy_after_start", Busy, 1'b1);
  endtask

  task automatic check_end(input string tag);
    check({tag, "_done"}, Done, ref_done);
    check({tag, "_error"}, Error, ref_err);
    check({tag, "_busy"}, Busy, 1'b0);
    check({tag, "_rdy"}, bus.InReady, 1'b0);
    check({tag, "_count"}, Count, ref_cnt);
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      bus.Addr = ADDR_W'(a);
      #1;
      check(tag, bus.Target, ref_tab[a]);
    end
  endtask

  initial begin
    bit stop;
    Reset       = 1'b1;
    Start       = 1'b0;
    bus.InValid = 1'b0;
    bus.InData  = 8'h00;
    bus.Addr    = '0;
    repeat (2) tick();
    Reset = 1'b0;
    model_clear();

    // Reset state
    check_end("reset");
    sweep("reset_tab");

    // Back-to-back records
    start_session();
    send_rec(8'h00, 16'h0F03, 0, stop);
    send_rec(8'h82, 16'h0003, 0, stop);
    check_end("b2b");
    sweep("b2b_tab");

    // Gapped record
    start_session();
    send_rec(8'h85, 16'hBEEF, 3, stop);
    check_end("gap");
    sweep("gap_tab");

    // Reserved bits abort, then a clean session
    start_session();
    send_rec(8'h25, 16'h0000, 0, stop);
    check_end("rsvd");
    sweep("rsvd_tab");
    start_session();
    send_rec(8'h81, 16'h1234, 0, stop);
    check_end("after_rsvd");
    sweep("after_rsvd_tab");

    // Timeout after the high byte
    start_session();
    push(8'h03, 0);
    push(8'hAB, 0);
    repeat (TMO - 1) tick();
    check("tmo_not_yet", Error, 1'b0);
    check("tmo_busy", Busy, 1'b1);
    tick();
    check("tmo_hit", Error, 1'b1);
    ref_err = 1;
    check_end("tmo");
    sweep("tmo_tab");

    // Reset mid-record clears everything
    start_session();
    push(8'h04, 0);
    push(8'h55, 0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    model_clear();
    check_end("midreset");
    sweep("midreset_tab");

    // Start while busy is ignored
    start_session();
    send_rec(8'h07, 16'hCAFE, 0, stop);
    check("cnt_before_start", Count, ref_cnt);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    check("cnt_after_start", Count, ref_cnt);
    check("busy_after_start2", Busy, 1'b1);
    send_rec(8'h88, 16'h0102, 1, stop);
    check_end("ign_start");
    sweep("ign_start_tab");

    // Random sessions; the first one overruns the Count saturation point
    for (int s = 0; s < 6; s++) begin
      int n;
      n = (s == 0) ? 40 : int'($urandom_range(1, 12));
      start_session();
      for (int i = 0; i < n; i++) begin
        logic [7:0]  b0;
        logic [1:0]  rsvd;
        logic [15:0] tgt;
        rsvd = ($urandom_range(0, 19) == 0 && s != 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        b0   = {(i == n - 1), rsvd, 5'($urandom_range(0, DEPTH - 1))};
        tgt  = 16'($urandom);
        send_rec(b0, tgt, int'($urandom_range(0, 3)), stop);
        if (stop) break;
      end
      check_end($sformatf("rand%0d", s));
      sweep($sformatf("rand%0d_tab", s));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
